// File: rtl/ntt_pkg.sv
// Shared types, sizing and the delay range check for the NTT delay bank.
package ntt_pkg;
  localparam int unsigned WIDTH         = 16;
  localparam int unsigned CH            = 2;
  localparam int unsigned MAX_DELAY     = 64;
  localparam int unsigned DEFAULT_DELAY = 4;
  localparam int unsigned DELAY_W       = $clog2(MAX_DELAY + 1);
  localparam int unsigned DEPTH         = MAX_DELAY - 1;
  localparam int unsigned ADDR_W        = $clog2(DEPTH);

  typedef logic [WIDTH-1:0]   lane_t;
  typedef logic [DELAY_W-1:0] delay_t;

  function automatic logic delay_ok(input delay_t d);
    return (d >= delay_t'(1)) && (d <= delay_t'(MAX_DELAY));
  endfunction
endpackage

// File: rtl/ntt_delay_ctr.sv
// Shared circular RAM address (wraps at delay-2) and saturating fill counter.
module ntt_delay_ctr
  import ntt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  delay_t            delay,
  output logic [ADDR_W-1:0] addr,
  output logic              primed,
  output logic              primed_nxt_c
);
  delay_t            fill;
  delay_t            fill_nxt;
  logic [ADDR_W-1:0] addr_nxt;

  always_comb begin
    fill_nxt     = (fill == delay) ? fill : fill + delay_t'(1);
    addr_nxt     = addr + ADDR_W'(1);
    primed_nxt_c = primed;
    // Short delays use at most one RAM word, so the address stays at zero.
    if ((delay < delay_t'(3)) || (delay_t'(addr) >= delay - delay_t'(2)))
      addr_nxt = '0;
    if (load)
      primed_nxt_c = 1'b0;
    else if (en)
      primed_nxt_c = (fill_nxt == delay);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr   <= '0;
      fill   <= '0;
      primed <= 1'b0;
    end else begin
      primed <= primed_nxt_c;
      if (load) begin
        addr <= '0;
        fill <= '0;
      end else if (en) begin
        addr <= addr_nxt;
        fill <= fill_nxt;
      end
    end
  end
endmodule

// File: rtl/ntt_delay_bank.sv
// Multi-lane runtime-programmable delay line with stall, valid and primed tracking.
// Optional per-lane even parity with parity_err output: define NTT_DELAY_PARITY_EN.
module ntt_delay_bank
  import ntt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_load,
  input  delay_t           cfg_delay,
  input  logic             in_valid,
  input  lane_t [CH-1:0]   in_data,
  output logic             out_valid,
  output lane_t [CH-1:0]   out_data,
  output logic             primed,
  output logic             cfg_err
`ifdef NTT_DELAY_PARITY_EN
  ,
  output logic [CH-1:0]    parity_err
`endif
);
`ifdef NTT_DELAY_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif
  localparam int unsigned LANE_W = WIDTH + PAR_W;
  localparam int unsigned MEM_W  = CH * LANE_W + 1;

  delay_t            cur_delay;
  logic              load_ok_c;
  logic              primed_nxt_c;
  logic [ADDR_W-1:0] addr;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  src_word;
  logic [MEM_W-1:0]  mem [DEPTH];

  assign load_ok_c = cfg_load && delay_ok(cfg_delay);

  ntt_delay_ctr u_ctr (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .load         (load_ok_c),
    .delay        (cur_delay),
    .addr         (addr),
    .primed       (primed),
    .primed_nxt_c (primed_nxt_c)
  );

  // Storage word: valid bit on top, then per lane {parity, data}.
  always_comb begin
    wr_word            = '0;
    wr_word[MEM_W-1]   = in_valid;
    for (int i = 0; i < CH; i++) begin
      wr_word[i*LANE_W +: WIDTH] = in_data[i];
`ifdef NTT_DELAY_PARITY_EN
      wr_word[i*LANE_W + WIDTH]  = ^in_data[i];
`endif
    end
  end

  // D=1 bypasses the RAM; D>=2 reads the word written D-1 enabled cycles ago.
  assign src_word = (cur_delay == delay_t'(1)) ? wr_word : mem[addr];

  always_ff @(posedge clk) begin
    if (en && !load_ok_c)
      mem[addr] <= wr_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_delay <= delay_t'(DEFAULT_DELAY);
      cfg_err   <= 1'b0;
    end else if (cfg_load) begin
      if (load_ok_c) begin
        cur_delay <= cfg_delay;
        cfg_err   <= 1'b0;
      end else begin
        cfg_err   <= 1'b1;
      end
    end
  end

`ifdef NTT_DELAY_PARITY_EN
  logic [CH-1:0] par_bad_c;
  always_comb begin
    par_bad_c = '0;
    for (int i = 0; i < CH; i++)
      par_bad_c[i] = ^src_word[i*LANE_W +: LANE_W];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
`ifdef NTT_DELAY_PARITY_EN
      parity_err <= '0;
`endif
    end else if (load_ok_c) begin
      out_valid  <= 1'b0;
`ifdef NTT_DELAY_PARITY_EN
      parity_err <= '0;
`endif
    end else if (en) begin
      for (int i = 0; i < CH; i++)
        out_data[i] <= src_word[i*LANE_W +: WIDTH];
      out_valid  <= src_word[MEM_W-1] && primed_nxt_c;
`ifdef NTT_DELAY_PARITY_EN
      parity_err <= par_bad_c & {CH{src_word[MEM_W-1] && primed_nxt_c}};
`endif
    end
  end
endmodule

// File: tb/tb_ntt_delay_bank.sv
// Directed, self-checking bench for ntt_delay_bank (ramps, stalls, loads, reset, parity).
module tb_ntt_delay_bank;
  import ntt_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic           cfg_load;
  delay_t         cfg_delay;
  logic           in_valid;
  lane_t [CH-1:0] in_data;
  logic           out_valid;
  lane_t [CH-1:0] out_data;
  logic           primed;
  logic           cfg_err;
`ifdef NTT_DELAY_PARITY_EN
  logic [CH-1:0]  parity_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ntt_delay_bank dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cfg_load   (cfg_load),
    .cfg_delay  (cfg_delay),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .primed     (primed),
    .cfg_err    (cfg_err)
`ifdef NTT_DELAY_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  typedef struct {
    logic en;
    int   din;
    logic exp_valid;
    int   exp_dout;
  } stall_vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic v, input int d);
    en         = e;
    in_valid   = v;
    in_data[0] = lane_t'(d);
    in_data[1] = lane_t'(d + 1000);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepted load: input on the load cycle is dropped, valid/primed/cfg_err clear.
  task automatic do_load(input int d);
    drive(1'b1, 1'b1, 9999);
    cfg_load  = 1'b1;
    cfg_delay = delay_t'(d);
    tick();
    cfg_load  = 1'b0;
    check("load_out_valid", int'(out_valid), 0);
    check("load_primed", int'(primed), 0);
    check("load_cfg_err", int'(cfg_err), 0);
  endtask

  // Ramp input base+k at enabled step k; output at step t must be base+t-d once t>=d.
  task automatic run_ramp(input int d, input int t0, input int n, input int base,
                          input int bad_at, input int bad_val, input bit err0);
    for (int k = t0; k < t0 + n; k++) begin
      int t;
      drive(1'b1, 1'b1, base + k);
      if (k == bad_at) begin
        cfg_load  = 1'b1;
        cfg_delay = delay_t'(bad_val);
      end
      tick();
      cfg_load = 1'b0;
      t = k + 1;
      check("ramp_valid", int'(out_valid), (t >= d) ? 1 : 0);
      check("ramp_primed", int'(primed), (t >= d) ? 1 : 0);
      if (t >= d) begin
        check("ramp_lane0", int'(out_data[0]), base + t - d);
        check("ramp_lane1", int'(out_data[1]), base + t - d + 1000);
      end
      check("ramp_cfg_err", int'(cfg_err), (err0 || (bad_at >= 0 && k >= bad_at)) ? 1 : 0);
    end
  endtask

  initial begin
    stall_vec_t svec [9];
    svec[0] = '{1'b1, 11, 1'b1, 8};
    svec[1] = '{1'b0, 99, 1'b1, 8};
    svec[2] = '{1'b0, 99, 1'b1, 8};
    svec[3] = '{1'b0, 99, 1'b1, 8};
    svec[4] = '{1'b1, 12, 1'b1, 9};
    svec[5] = '{1'b1, 13, 1'b1, 10};
    svec[6] = '{1'b1, 14, 1'b1, 11};
    svec[7] = '{1'b1, 15, 1'b1, 12};
    svec[8] = '{1'b1, 16, 1'b1, 13};

    rst       = 1'b1;
    cfg_load  = 1'b0;
    cfg_delay = '0;
    drive(1'b0, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_primed", int'(primed), 0);
    check("rst_cfg_err", int'(cfg_err), 0);
    check("rst_lane0", int'(out_data[0]), 0);
    check("rst_lane1", int'(out_data[1]), 0);
    rst = 1'b0;

    // Default D=4 ramp 1,2,3,...
    run_ramp(4, 0, 10, 1, -1, 0, 1'b0);

    // Stall mid-stream: output frozen, then resumes without gap or duplicate.
    for (int i = 0; i < 9; i++) begin
      drive(svec[i].en, 1'b1, svec[i].din);
      tick();
      check("stall_valid", int'(out_valid), int'(svec[i].exp_valid));
      check("stall_lane0", int'(out_data[0]), svec[i].exp_dout);
      check("stall_lane1", int'(out_data[1]), svec[i].exp_dout + 1000);
    end

    // Minimum, short and maximum delays.
    do_load(1);
    run_ramp(1, 0, 5, 200, -1, 0, 1'b0);
    do_load(2);
    run_ramp(2, 0, 6, 300, -1, 0, 1'b0);
    do_load(64);
    run_ramp(64, 0, 70, 400, -1, 0, 1'b0);

    // Rejected loads (0, then 65) leave the D=4 stream running; cfg_err sticks.
    do_load(4);
    run_ramp(4, 0, 8, 600, 5, 0, 1'b0);
    run_ramp(4, 8, 6, 600, 10, 65, 1'b1);
    do_load(8);

    // Reset pulse while primed at D=8: outputs clear at once, D returns to default.
    run_ramp(8, 0, 10, 700, -1, 0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_primed", int'(primed), 0);
    check("arst_lane0", int'(out_data[0]), 0);
    check("arst_lane1", int'(out_data[1]), 0);
    @(negedge clk);
    rst = 1'b0;
    run_ramp(4, 0, 6, 750, -1, 0, 1'b0);

`ifdef NTT_DELAY_PARITY_EN
    // Corrupt lane 1 bit 0 of the word holding input k=3 at D=16.
    do_load(16);
    for (int k = 0; k < 24; k++) begin
      drive(1'b1, 1'b1, 800 + k);
      tick();
      if (k == 3)
        dut.mem[3][WIDTH + 1] = ~dut.mem[3][WIDTH + 1];
      check("parity_err", int'(parity_err), (k + 1 == 19) ? 2 : 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
